sobel_gradient_pipe: RTL and testbench
======================================

Name: sobel_gradient_pipe

Overview:
- Parametrised, pipelined successor to the team's multi-cycle Sobel edge-detection FSM.
- Accepts one 3x3 pixel window per cycle over a valid/ready handshake and computes Gx and Gy.
- Produces a saturated L1 magnitude, a thresholded binary edge, or a single-axis magnitude, selected by a mode input, plus a 2-bit dominant-direction code.
- Sits between the line-buffer/window generator and the output pixel writer.

Parameters:
- PIX_W, 8: pixel and output width in bits (4..16).
- CNT_W, 16: width of the processed-pixel counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- i_window_valid  input  1  window present on i_window.
- o_window_ready  output  1  block accepts i_window this cycle.
- i_window  input  9*PIX_W  P0..P8 row-major, P0 = top-left, P0 in the LSBs, unsigned.
- i_mode  input  2  0=MAG, 1=THRESH, 2=GX_ONLY, 3=GY_ONLY; captured with the window.
- i_threshold  input  PIX_W  THRESH compare value; captured with the window.
- o_gradient_valid  output  1  result valid.
- i_gradient_ready  input  1  downstream accepts the result.
- o_processed_sum  output  PIX_W  result pixel.
- o_direction  output  2  bit1 = |Gy|>|Gx|; bit0 = sign of the dominant component (1 = negative).
- o_saturated  output  1  magnitude clipped to the maximum value.
- o_pixel_count  output  CNT_W  number of results handed off since reset; wraps.

Behaviour:
- Reset: rst=1 at a clk edge clears every stage valid and data register. Outputs go to o_gradient_valid=0, o_processed_sum=0, o_direction=0, o_saturated=0, o_pixel_count=0. o_window_ready=1 from the first cycle after reset. In-flight windows are discarded and never emitted.
- Handshake:
  - advance = !o_gradient_valid | i_gradient_ready.
  - o_window_ready = advance (combinational).
  - Input transfer occurs when i_window_valid & o_window_ready.
  - Output transfer occurs when o_gradient_valid & i_gradient_ready.
  - While o_gradient_valid=1 and i_gradient_ready=0, all outputs hold stable.
- Pipeline: 4 stages, all gated by advance, so stages stall together and bubbles are preserved. Latency is 4 cycles from input transfer to o_gradient_valid with no stall. Throughput is 1 window per cycle.
  - S1: signed differences, PIX_W+1 bits each.
    - X: P2-P0, P5-P3, P8-P6.
    - Y: P0-P6, P1-P7, P2-P8.
  - S2: Gx = dX0 + 2*dX1 + dX2; Gy = dY0 + 2*dY1 + dY2; both signed, PIX_W+3 bits, no overflow possible.
  - S3: |Gx| and |Gy|, unsigned PIX_W+2 bits; the direction code is formed here.
    - Tie (|Gx|==|Gy|) gives bit1=0.
    - Zero gradient gives direction 00.
  - S4: raw = |Gx|+|Gy| (PIX_W+3 bits). The mode selects the source value: MAG uses raw, GX_ONLY uses |Gx|, GY_ONLY uses |Gy|.
    - sat = source > 2^PIX_W-1.
    - MAG/GX_ONLY/GY_ONLY: o_processed_sum = sat ? all ones : source[PIX_W-1:0].
    - THRESH: o_processed_sum = (saturated MAG value >= i_threshold captured) ? all ones : 0.
    - o_saturated = sat of the source selected by the mode (MAG for THRESH).
- Mode and threshold travel with their window; changing them mid-stream affects only later windows.
- o_pixel_count increments on each output transfer; it wraps from 2^CNT_W-1 to 0.
- Simultaneous input and output transfer in the same cycle is legal and yields sustained 1/cycle throughput.
- No combinational path from i_window to any output.

Decomposition:
- Package edge_pkg:
  - mode_t enum (MODE_MAG, MODE_THRESH, MODE_GX, MODE_GY).
  - Direction bit-position constants.
  - Width localparams derived from PIX_W (DIFF_W=PIX_W+1, G_W=PIX_W+3, ABS_W=PIX_W+2).
- Sub-module sobel_axis: S1+S2 for one axis, parametrised by PIX_W. It takes six pixel inputs (the minuend/subtrahend pairs) plus advance, outputs signed G. It is instantiated twice, for X and Y tap mappings.

Test Plan:
- PIX_W=8, MAG, all pixels 100, ready held 1 → after 4 cycles: sum=0, direction=00, saturated=0, pixel_count=1.
- MAG; left column 0, middle 128, right column 255 → Gx=1020, Gy=0: sum=255, saturated=1, direction=00.
- MAG; P0=10, others 0 → Gx=-10, Gy=10: sum=20, direction=01 (tie, Gx negative), saturated=0.
- Same window in THRESH with threshold=20 → sum=255; threshold=21 → sum=0; back-to-back with the modes alternating per window gives the results in order.
- Push 5 windows, i_gradient_ready=0 for 6 cycles → o_window_ready drops once a result is valid; the outputs hold stable. After ready rises, all 5 results drain in order with no loss or duplicate, and pixel_count=5.
- Reset asserted for 1 cycle with 3 windows in flight → next cycle valid=0 and count=0; none of those results appears. A new window after reset appears 4 cycles later with the correct value.

Source files
------------

// File: rtl/sobel_gradient_pipe_pkg.sv
// Shared types and width helpers for the Sobel gradient pipeline.
package edge_pkg;

  typedef enum logic [1:0] {
    MODE_MAG    = 2'd0,
    MODE_THRESH = 2'd1,
    MODE_GX     = 2'd2,
    MODE_GY     = 2'd3
  } mode_t;

  localparam int unsigned DIR_DOM_Y_BIT = 1;
  localparam int unsigned DIR_NEG_BIT   = 0;

  localparam int DEFAULT_PIX_W = 8;
  localparam int DIFF_W        = DEFAULT_PIX_W + 1;
  localparam int G_W           = DEFAULT_PIX_W + 3;
  localparam int ABS_W         = DEFAULT_PIX_W + 2;

  function automatic int diff_w(input int pix_w);
    return pix_w + 1;
  endfunction

  function automatic int g_w(input int pix_w);
    return pix_w + 3;
  endfunction

  function automatic int abs_w(input int pix_w);
    return pix_w + 2;
  endfunction

endpackage

// File: rtl/sobel_gradient_pipe_axis.sv
// One Sobel axis: three pixel differences (S1) then the 1-2-1 weighted sum (S2).
module sobel_axis
  import edge_pkg::*;
#(
  parameter int PIX_W = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_advance,
  input  logic [PIX_W-1:0]                i_min0,
  input  logic [PIX_W-1:0]                i_sub0,
  input  logic [PIX_W-1:0]                i_min1,
  input  logic [PIX_W-1:0]                i_sub1,
  input  logic [PIX_W-1:0]                i_min2,
  input  logic [PIX_W-1:0]                i_sub2,
  output logic signed [g_w(PIX_W)-1:0]    o_g
);

  localparam int DW = diff_w(PIX_W);
  localparam int GW = g_w(PIX_W);

  logic signed [DW-1:0] r_d0, r_d1, r_d2;
  logic signed [GW-1:0] w_e0, w_e1, w_e2;
  logic signed [GW-1:0] r_g;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_d0 <= '0;
      r_d1 <= '0;
      r_d2 <= '0;
    end else if (i_advance) begin
      r_d0 <= $signed({1'b0, i_min0}) - $signed({1'b0, i_sub0});
      r_d1 <= $signed({1'b0, i_min1}) - $signed({1'b0, i_sub1});
      r_d2 <= $signed({1'b0, i_min2}) - $signed({1'b0, i_sub2});
    end
  end

  always_comb begin
    w_e0 = {{(GW-DW){r_d0[DW-1]}}, r_d0};
    w_e1 = {{(GW-DW){r_d1[DW-1]}}, r_d1};
    w_e2 = {{(GW-DW){r_d2[DW-1]}}, r_d2};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_g <= '0;
    end else if (i_advance) begin
      r_g <= w_e0 + (w_e1 <<< 1) + w_e2;
    end
  end

  assign o_g = r_g;

endmodule

// File: rtl/sobel_gradient_pipe.sv
// Four-stage Sobel gradient pipeline with valid/ready handshake and mode-selected result.
module sobel_gradient_pipe
  import edge_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_window_valid,
  output logic               o_window_ready,
  input  logic [9*PIX_W-1:0] i_window,
  input  logic [1:0]         i_mode,
  input  logic [PIX_W-1:0]   i_threshold,
  output logic               o_gradient_valid,
  input  logic               i_gradient_ready,
  output logic [PIX_W-1:0]   o_processed_sum,
  output logic [1:0]         o_direction,
  output logic               o_saturated,
  output logic [CNT_W-1:0]   o_pixel_count
);

  localparam int GW = g_w(PIX_W);
  localparam int AW = abs_w(PIX_W);

  logic             w_advance;
  logic             w_in_xfer;
  logic             w_out_xfer;
  logic [PIX_W-1:0] w_p [9];

  logic             r_v1, r_v2, r_v3, r_v4;
  mode_t            r_mode1, r_mode2, r_mode3;
  logic [PIX_W-1:0] r_thr1, r_thr2, r_thr3;

  logic signed [GW-1:0] w_gx, w_gy;
  logic [AW-1:0]        w_absx, w_absy;
  logic                 w_y_dom;
  logic [1:0]           w_dir3;
  logic [AW-1:0]        r_absx, r_absy;
  logic [1:0]           r_dir3;

  logic [GW-1:0]    w_raw, w_src;
  logic             w_sat;
  logic [PIX_W-1:0] w_clip, w_sum4;
  logic [PIX_W-1:0] r_sum;
  logic [1:0]       r_dir;
  logic             r_sat;
  logic [CNT_W-1:0] r_cnt;

  for (genvar k = 0; k < 9; k++) begin : g_pix
    assign w_p[k] = i_window[k*PIX_W +: PIX_W];
  end

  // Every stage shares one enable so bubbles and stalls move in lockstep.
  assign w_advance  = !r_v4 || i_gradient_ready;
  assign w_in_xfer  = i_window_valid && w_advance;
  assign w_out_xfer = r_v4 && i_gradient_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_v3    <= 1'b0;
      r_v4    <= 1'b0;
      r_mode1 <= MODE_MAG;
      r_mode2 <= MODE_MAG;
      r_mode3 <= MODE_MAG;
      r_thr1  <= '0;
      r_thr2  <= '0;
      r_thr3  <= '0;
    end else if (w_advance) begin
      r_v1    <= w_in_xfer;
      r_v2    <= r_v1;
      r_v3    <= r_v2;
      r_v4    <= r_v3;
      r_mode1 <= mode_t'(i_mode);
      r_mode2 <= r_mode1;
      r_mode3 <= r_mode2;
      r_thr1  <= i_threshold;
      r_thr2  <= r_thr1;
      r_thr3  <= r_thr2;
    end
  end

  sobel_axis #(.PIX_W(PIX_W)) u_axis_x (
    .clk       (clk),
    .rst       (rst),
    .i_advance (w_advance),
    .i_min0    (w_p[2]),
    .i_sub0    (w_p[0]),
    .i_min1    (w_p[5]),
    .i_sub1    (w_p[3]),
    .i_min2    (w_p[8]),
    .i_sub2    (w_p[6]),
    .o_g       (w_gx)
  );

  sobel_axis #(.PIX_W(PIX_W)) u_axis_y (
    .clk       (clk),
    .rst       (rst),
    .i_advance (w_advance),
    .i_min0    (w_p[0]),
    .i_sub0    (w_p[6]),
    .i_min1    (w_p[1]),
    .i_sub1    (w_p[7]),
    .i_min2    (w_p[2]),
    .i_sub2    (w_p[8]),
    .o_g       (w_gy)
  );

  // Ties resolve to the X axis, so a zero gradient yields direction 00.
  always_comb begin
    w_absx  = w_gx[GW-1] ? AW'(-w_gx) : AW'(w_gx);
    w_absy  = w_gy[GW-1] ? AW'(-w_gy) : AW'(w_gy);
    w_y_dom = w_absy > w_absx;
    w_dir3  = '0;
    w_dir3[DIR_DOM_Y_BIT] = w_y_dom;
    w_dir3[DIR_NEG_BIT]   = w_y_dom ? w_gy[GW-1] : w_gx[GW-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_absx <= '0;
      r_absy <= '0;
      r_dir3 <= '0;
    end else if (w_advance) begin
      r_absx <= w_absx;
      r_absy <= w_absy;
      r_dir3 <= w_dir3;
    end
  end

  // THRESH compares against the clipped MAG value, so it shares the MAG source.
  always_comb begin
    w_raw = GW'(r_absx) + GW'(r_absy);
    w_src = w_raw;
    unique case (r_mode3)
      MODE_GX: w_src = GW'(r_absx);
      MODE_GY: w_src = GW'(r_absy);
      default: w_src = w_raw;
    endcase
    w_sat  = |w_src[GW-1:PIX_W];
    w_clip = w_sat ? '1 : w_src[PIX_W-1:0];
    w_sum4 = w_clip;
    if (r_mode3 == MODE_THRESH) begin
      w_sum4 = (w_clip >= r_thr3) ? '1 : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum <= '0;
      r_dir <= '0;
      r_sat <= 1'b0;
    end else if (w_advance) begin
      r_sum <= w_sum4;
      r_dir <= r_dir3;
      r_sat <= w_sat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_out_xfer) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_window_ready   = w_advance;
  assign o_gradient_valid = r_v4;
  assign o_processed_sum  = r_sum;
  assign o_direction      = r_dir;
  assign o_saturated      = r_sat;
  assign o_pixel_count    = r_cnt;

endmodule

// File: tb/tb_sobel_gradient_pipe.sv
// Self-checking bench for sobel_gradient_pipe against an arithmetic reference model.
module tb_sobel_gradient_pipe;

  localparam int PW   = 8;
  localparam int CW   = 4;
  localparam int MAXV = (1 << PW) - 1;

  typedef struct packed {
    logic [PW-1:0] sum;
    logic [1:0]    dir;
    logic          sat;
  } res_t;

  typedef struct {
    logic [9*PW-1:0] win;
    logic [1:0]      md;
    logic [PW-1:0]   thr;
    res_t            exp;
  } dcase_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            i_window_valid = 1'b0;
  logic            o_window_ready;
  logic [9*PW-1:0] i_window = '0;
  logic [1:0]      i_mode = '0;
  logic [PW-1:0]   i_threshold = '0;
  logic            o_gradient_valid;
  logic            i_gradient_ready = 1'b0;
  logic [PW-1:0]   o_processed_sum;
  logic [1:0]      o_direction;
  logic            o_saturated;
  logic [CW-1:0]   o_pixel_count;

  always #5 clk = ~clk;

  sobel_gradient_pipe #(.PIX_W(PW), .CNT_W(CW)) dut (
    .clk              (clk),
    .rst              (rst),
    .i_window_valid   (i_window_valid),
    .o_window_ready   (o_window_ready),
    .i_window         (i_window),
    .i_mode           (i_mode),
    .i_threshold      (i_threshold),
    .o_gradient_valid (o_gradient_valid),
    .i_gradient_ready (i_gradient_ready),
    .o_processed_sum  (o_processed_sum),
    .o_direction      (o_direction),
    .o_saturated      (o_saturated),
    .o_pixel_count    (o_pixel_count)
  );

  int   checks = 0;
  int   failures = 0;
  int   cnt_model = 0;
  res_t q[$];

  function automatic res_t model(input logic [9*PW-1:0] win, input logic [1:0] md,
                                 input logic [PW-1:0] thr);
    int p[9];
    int gx, gy, ax, ay, mag, src, magc;
    res_t r;
    for (int k = 0; k < 9; k++) p[k] = int'(win[k*PW +: PW]);
    gx = (p[2] - p[0]) + 2 * (p[5] - p[3]) + (p[8] - p[6]);
    gy = (p[0] - p[6]) + 2 * (p[1] - p[7]) + (p[2] - p[8]);
    ax = (gx < 0) ? -gx : gx;
    ay = (gy < 0) ? -gy : gy;
    mag = ax + ay;
    case (md)
      2'd2:    src = ax;
      2'd3:    src = ay;
      default: src = mag;
    endcase
    r.sat = (src > MAXV);
    magc  = (mag > MAXV) ? MAXV : mag;
    if (md == 2'd1) r.sum = (magc >= int'(thr)) ? PW'(MAXV) : '0;
    else            r.sum = PW'((src > MAXV) ? MAXV : src);
    if (ay > ax) r.dir = {1'b1, gy < 0};
    else         r.dir = {1'b0, gx < 0};
    return r;
  endfunction

  function automatic logic [9*PW-1:0] rand_win();
    logic [9*PW-1:0] w;
    int sel;
    w = '0;
    for (int k = 0; k < 9; k++) begin
      sel = $urandom_range(0, 3);
      if (sel == 0)      w[k*PW +: PW] = '0;
      else if (sel == 1) w[k*PW +: PW] = PW'(MAXV);
      else               w[k*PW +: PW] = PW'($urandom_range(0, MAXV));
    end
    return w;
  endfunction

  // Drives one cycle of inputs, samples outputs mid-cycle, then crosses the next edge.
  task automatic step(input bit v, input logic [9*PW-1:0] win, input logic [1:0] md,
                      input logic [PW-1:0] thr, input bit rdy,
                      output bit in_x, output bit out_x, output bit ovld, output res_t got);
    i_window_valid   = v;
    i_window         = win;
    i_mode           = md;
    i_threshold      = thr;
    i_gradient_ready = rdy;
    #1;
    in_x  = v && o_window_ready;
    ovld  = o_gradient_valid;
    out_x = o_gradient_valid && rdy;
    got   = '{o_processed_sum, o_direction, o_saturated};
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bit in_x, out_x, ovld;
    res_t got;
    rst = 1'b1;
    for (int c = 0; c < 3; c++) step(1'b1, rand_win(), 2'd0, '0, 1'b1, in_x, out_x, ovld, got);
    rst = 1'b0;
    i_gradient_ready = 1'b0;
    i_window_valid   = 1'b0;
    #1;
    checks++;
    if (o_gradient_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b req=0", o_gradient_valid); end
    checks++;
    if (o_processed_sum !== '0) begin failures++; $display("FAIL reset_sum got=%0d req=0", o_processed_sum); end
    checks++;
    if (o_direction !== 2'b00) begin failures++; $display("FAIL reset_dir got=%b req=00", o_direction); end
    checks++;
    if (o_saturated !== 1'b0) begin failures++; $display("FAIL reset_sat got=%b req=0", o_saturated); end
    checks++;
    if (o_pixel_count !== '0) begin failures++; $display("FAIL reset_count got=%0d req=0", o_pixel_count); end
    checks++;
    if (o_window_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b req=1", o_window_ready); end
    cnt_model = 0;
  endtask

  task automatic test_directed();
    dcase_t tbl[9];
    logic [9*PW-1:0] flat, cols, p0;
    bit in_x, out_x, ovld;
    res_t got;
    flat = '0; cols = '0; p0 = '0;
    for (int k = 0; k < 9; k++) begin
      flat[k*PW +: PW] = PW'(100);
      cols[k*PW +: PW] = (k % 3 == 0) ? PW'(0) : ((k % 3 == 1) ? PW'(128) : PW'(255));
    end
    p0[PW-1:0] = PW'(10);
    tbl[0] = '{flat, 2'd0, PW'(0),   '{PW'(0),   2'b00, 1'b0}};
    tbl[1] = '{cols, 2'd0, PW'(0),   '{PW'(255), 2'b00, 1'b1}};
    tbl[2] = '{p0,   2'd0, PW'(0),   '{PW'(20),  2'b01, 1'b0}};
    tbl[3] = '{p0,   2'd1, PW'(20),  '{PW'(255), 2'b01, 1'b0}};
    tbl[4] = '{p0,   2'd1, PW'(21),  '{PW'(0),   2'b01, 1'b0}};
    tbl[5] = '{cols, 2'd2, PW'(0),   '{PW'(255), 2'b00, 1'b1}};
    tbl[6] = '{p0,   2'd3, PW'(0),   '{PW'(10),  2'b01, 1'b0}};
    tbl[7] = '{cols, 2'd1, PW'(255), '{PW'(255), 2'b00, 1'b1}};
    tbl[8] = '{cols, 2'd3, PW'(0),   '{PW'(0),   2'b00, 1'b0}};
    for (int i = 0; i < 9; i++) begin
      step(1'b1, tbl[i].win, tbl[i].md, tbl[i].thr, 1'b1, in_x, out_x, ovld, got);
      checks++;
      if (!in_x) begin failures++; $display("FAIL dir_accept case=%0d got=0 req=1", i); end
      for (int b = 0; b < 4; b++) begin
        step(1'b0, rand_win(), 2'($urandom_range(0, 3)), PW'($urandom), 1'b1, in_x, out_x, ovld, got);
        checks++;
        if (out_x !== (b == 3)) begin
          failures++; $display("FAIL dir_latency case=%0d cyc=%0d got_valid=%b req=%b", i, b + 1, out_x, b == 3);
        end
      end
      checks++;
      if (got !== tbl[i].exp) begin
        failures++;
        $display("FAIL dir_result case=%0d got sum=%0d dir=%b sat=%b req sum=%0d dir=%b sat=%b",
                 i, got.sum, got.dir, got.sat, tbl[i].exp.sum, tbl[i].exp.dir, tbl[i].exp.sat);
      end
      cnt_model++;
      checks++;
      if (o_pixel_count !== CW'(cnt_model)) begin
        failures++; $display("FAIL dir_count case=%0d got=%0d req=%0d", i, o_pixel_count, CW'(cnt_model));
      end
    end
  endtask

  task automatic test_back_to_back();
    localparam int N = 16;
    logic [9*PW-1:0] win;
    logic [1:0] md;
    logic [PW-1:0] thr;
    bit in_x, out_x, ovld;
    res_t got, exp;
    int sent = 0;
    int c = 0;
    win = rand_win(); md = 2'd0; thr = PW'($urandom);
    q.delete();
    for (c = 0; c < 200 && (sent < N || q.size() > 0); c++) begin
      step(sent < N, win, md, thr, 1'b1, in_x, out_x, ovld, got);
      if (in_x) begin
        q.push_back(model(win, md, thr));
        sent++;
        win = rand_win(); md = (sent % 2 == 1) ? 2'd1 : 2'd0; thr = PW'($urandom);
      end
      if (out_x) begin
        checks++;
        if (q.size() == 0) begin
          failures++; $display("FAIL b2b_extra got sum=%0d req=none", got.sum);
        end else begin
          exp = q.pop_front();
          if (got !== exp) begin
            failures++;
            $display("FAIL b2b_result got sum=%0d dir=%b sat=%b req sum=%0d dir=%b sat=%b",
                     got.sum, got.dir, got.sat, exp.sum, exp.dir, exp.sat);
          end
        end
        cnt_model++;
      end
    end
    checks++;
    if (c != N + 4) begin failures++; $display("FAIL b2b_throughput cycles=%0d req=%0d", c, N + 4); end
    checks++;
    if (o_pixel_count !== CW'(cnt_model)) begin
      failures++; $display("FAIL b2b_count got=%0d req=%0d", o_pixel_count, CW'(cnt_model));
    end
  endtask

  task automatic test_stall();
    logic [9*PW-1:0] win;
    logic [1:0] md;
    logic [PW-1:0] thr;
    bit in_x, out_x, ovld, rdy, prev_stall;
    res_t got, exp, prev_got;
    int sent = 0;
    int stalls = 0;
    int base = cnt_model;
    prev_stall = 1'b0; prev_got = '0;
    win = rand_win(); md = 2'($urandom_range(0, 3)); thr = PW'($urandom);
    q.delete();
    for (int c = 0; c < 200 && (sent < 5 || q.size() > 0); c++) begin
      rdy = (c >= 10);
      step(sent < 5, win, md, thr, rdy, in_x, out_x, ovld, got);
      if (prev_stall) begin
        checks++;
        if (!ovld || got !== prev_got) begin
          failures++; $display("FAIL stall_hold got valid=%b sum=%0d req valid=1 sum=%0d", ovld, got.sum, prev_got.sum);
        end
      end
      if (ovld && !rdy && sent < 5) begin
        checks++;
        if (in_x) begin failures++; $display("FAIL stall_ready got=1 req=0"); end
      end
      if (ovld && !rdy) stalls++;
      prev_stall = ovld && !rdy;
      prev_got   = got;
      if (in_x) begin
        q.push_back(model(win, md, thr));
        sent++;
        win = rand_win(); md = 2'($urandom_range(0, 3)); thr = PW'($urandom);
      end
      if (out_x) begin
        checks++;
        if (q.size() == 0) begin
          failures++; $display("FAIL stall_extra got sum=%0d req=none", got.sum);
        end else begin
          exp = q.pop_front();
          if (got !== exp) begin
            failures++;
            $display("FAIL stall_result got sum=%0d dir=%b sat=%b req sum=%0d dir=%b sat=%b",
                     got.sum, got.dir, got.sat, exp.sum, exp.dir, exp.sat);
          end
        end
        cnt_model++;
      end
    end
    checks++;
    if (sent != 5 || q.size() != 0 || stalls != 6) begin
      failures++; $display("FAIL stall_drain sent=%0d pending=%0d stalls=%0d req 5/0/6", sent, q.size(), stalls);
    end
    checks++;
    if (o_pixel_count !== CW'(base + 5)) begin
      failures++; $display("FAIL stall_count got=%0d req=%0d", o_pixel_count, CW'(base + 5));
    end
  endtask

  task automatic test_random();
    localparam int N = 300;
    logic [9*PW-1:0] win;
    logic [1:0] md;
    logic [PW-1:0] thr;
    bit in_x, out_x, ovld, v, rdy, prev_stall;
    res_t got, exp, prev_got;
    int sent = 0;
    prev_stall = 1'b0; prev_got = '0;
    win = rand_win(); md = 2'($urandom_range(0, 3)); thr = PW'($urandom);
    q.delete();
    for (int c = 0; c < 5000 && (sent < N || q.size() > 0); c++) begin
      v   = (sent < N) && ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 9) < 7);
      step(v, win, md, thr, rdy, in_x, out_x, ovld, got);
      if (prev_stall) begin
        checks++;
        if (!ovld || got !== prev_got) begin
          failures++; $display("FAIL rand_hold got valid=%b sum=%0d req valid=1 sum=%0d", ovld, got.sum, prev_got.sum);
        end
      end
      prev_stall = ovld && !rdy;
      prev_got   = got;
      if (in_x) begin
        q.push_back(model(win, md, thr));
        sent++;
        win = rand_win(); md = 2'($urandom_range(0, 3)); thr = PW'($urandom);
      end
      if (out_x) begin
        checks++;
        if (q.size() == 0) begin
          failures++; $display("FAIL rand_extra got sum=%0d req=none", got.sum);
        end else begin
          exp = q.pop_front();
          if (got !== exp) begin
            failures++;
            $display("FAIL rand_result got sum=%0d dir=%b sat=%b req sum=%0d dir=%b sat=%b",
                     got.sum, got.dir, got.sat, exp.sum, exp.dir, exp.sat);
          end
        end
        cnt_model++;
      end
    end
    checks++;
    if (sent != N || q.size() != 0) begin
      failures++; $display("FAIL rand_drain sent=%0d pending=%0d req %0d/0", sent, q.size(), N);
    end
    checks++;
    if (o_pixel_count !== CW'(cnt_model)) begin
      failures++; $display("FAIL rand_count got=%0d req=%0d", o_pixel_count, CW'(cnt_model));
    end
  endtask

  task automatic test_reset_inflight();
    logic [9*PW-1:0] win;
    bit in_x, out_x, ovld;
    res_t got, exp;
    for (int i = 0; i < 3; i++) step(1'b1, rand_win(), 2'd0, '0, 1'b1, in_x, out_x, ovld, got);
    rst = 1'b1;
    step(1'b0, rand_win(), 2'd0, '0, 1'b1, in_x, out_x, ovld, got);
    rst = 1'b0;
    q.delete();
    cnt_model = 0;
    checks++;
    if (o_gradient_valid !== 1'b0) begin failures++; $display("FAIL rst_flight_valid got=%b req=0", o_gradient_valid); end
    checks++;
    if (o_pixel_count !== '0) begin failures++; $display("FAIL rst_flight_count got=%0d req=0", o_pixel_count); end
    win = rand_win();
    exp = model(win, 2'd0, '0);
    step(1'b1, win, 2'd0, '0, 1'b1, in_x, out_x, ovld, got);
    checks++;
    if (out_x || !in_x) begin failures++; $display("FAIL rst_flight_accept got out=%b in=%b req out=0 in=1", out_x, in_x); end
    for (int b = 0; b < 4; b++) begin
      step(1'b0, rand_win(), 2'd0, '0, 1'b1, in_x, out_x, ovld, got);
      checks++;
      if (out_x !== (b == 3)) begin
        failures++; $display("FAIL rst_flight_latency cyc=%0d got_valid=%b req=%b", b + 1, out_x, b == 3);
      end
    end
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL rst_flight_result got sum=%0d dir=%b sat=%b req sum=%0d dir=%b sat=%b",
               got.sum, got.dir, got.sat, exp.sum, exp.dir, exp.sat);
    end
    checks++;
    if (o_pixel_count !== CW'(1)) begin failures++; $display("FAIL rst_flight_count_after got=%0d req=1", o_pixel_count); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall();
    test_random();
    test_reset_inflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
